// File: rtl/jtag_dbg_pkg.sv
// Shared IR codes, default widths and the command record for the JTAG debug clk-side bridge.
package jtag_dbg_pkg;

    localparam int JTAG_DEFAULT_DATA_W  = 38;
    localparam int JTAG_DEFAULT_IR_W    = 2;
    localparam int JTAG_DEFAULT_ACT_BIT = 34;
    localparam int JTAG_MIN_SYNC_STAGES = 2;

    localparam logic [JTAG_DEFAULT_IR_W-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [JTAG_DEFAULT_IR_W-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [JTAG_DEFAULT_IR_W-1:0] IR_BREAK     = 2'd2;
    localparam logic [JTAG_DEFAULT_IR_W-1:0] IR_TRACECTRL = 2'd3;

    typedef struct packed {
        logic [JTAG_DEFAULT_IR_W-1:0]   ir;
        logic [JTAG_DEFAULT_DATA_W-1:0] data;
    } jtag_cmd_t;

endpackage

// File: rtl/jtag_sync_edge.sv
// Level synchroniser into clk plus registered rising-edge pulse; ignores a level already high at reset release.
// Latency: level rise to rise_p high is STAGES+1 clk cycles; rise_p lasts exactly one cycle.
// Backpressure: none; free-running.
module jtag_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise_p
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              hist_q;
    logic              armed_q;
    logic              rise_q;

    // fill_q tracks when sync_q holds real samples rather than reset zeros, so a
    // genuine low must be observed before any rise is reported.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], level};
            fill_q  <= {fill_q[STAGES-2:0], 1'b1};
            hist_q  <= sync_q[STAGES-1];
            armed_q <= armed_q | (fill_q[STAGES-1] & ~sync_q[STAGES-1]);
            rise_q  <= sync_q[STAGES-1] & ~hist_q & armed_q;
        end
    end

    assign rise_p = rise_q;

endmodule

// File: rtl/jtag_debug_sysclk_bridge.sv
// JTAG debug bridge, clk side: syncs UIR/UDR strobes, latches IR and SR, emits one-hot action/no-action strobes.
// Latency: vs_udr rise to jdo/cmd_valid/strobe is SYNC_STAGES+2 clk cycles; strobes last one cycle.
// Backpressure: cmd_valid/cmd_ready; a new command overwrites an unconsumed one and sets sticky overrun.
// Optional JTAG_BRIDGE_PARITY_EN: sr[DATA_W-1] is even parity, bad commands are dropped and flag parity_err.
module jtag_debug_sysclk_bridge
    import jtag_dbg_pkg::*;
#(
    parameter int DATA_W      = JTAG_DEFAULT_DATA_W,
    parameter int IR_W        = JTAG_DEFAULT_IR_W,
    parameter int ACT_BIT     = JTAG_DEFAULT_ACT_BIT,
    parameter int SYNC_STAGES = JTAG_MIN_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    output logic [DATA_W-1:0]    jdo,
    output logic [IR_W-1:0]      cmd_ir,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [(2**IR_W)-1:0] take_action,
    output logic [(2**IR_W)-1:0] take_no_action,
    output logic                 overrun,
    input  logic                 overrun_clr
`ifdef JTAG_BRIDGE_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int NUM_CMD = 2**IR_W;
    localparam int SYNC_N  = (SYNC_STAGES < JTAG_MIN_SYNC_STAGES) ? JTAG_MIN_SYNC_STAGES : SYNC_STAGES;

    typedef struct packed {
        logic [IR_W-1:0]   ir;
        logic [DATA_W-1:0] data;
    } cmd_rec_t;

    logic               uir_p;
    logic               udr_p;
    logic [IR_W-1:0]    ir_q;
    cmd_rec_t           cmd_q;
    logic               cmd_valid_q;
    logic               overrun_q;
    logic [NUM_CMD-1:0] act_q;
    logic [NUM_CMD-1:0] no_act_q;
    logic [NUM_CMD-1:0] ir_onehot;
    logic               parity_ok;
    logic               cmd_accept;
    logic               handshake;

    jtag_sync_edge #(.STAGES(SYNC_N)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (vs_uir),
        .rise_p  (uir_p)
    );

    jtag_sync_edge #(.STAGES(SYNC_N)) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (vs_udr),
        .rise_p  (udr_p)
    );

    always_comb begin
        ir_onehot       = '0;
        ir_onehot[ir_q] = 1'b1;
    end

`ifdef JTAG_BRIDGE_PARITY_EN
    logic parity_err_q;

    // Even parity across the whole word, parity bit included, must come out zero.
    assign parity_ok = ~(^sr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_err_q <= 1'b0;
        end else if (udr_p && !parity_ok) begin
            parity_err_q <= 1'b1;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_ok = 1'b1;
`endif

    assign cmd_accept = udr_p & parity_ok;
    assign handshake  = cmd_valid_q & cmd_ready;

    // The command always takes the ir_q held before this edge, so a coincident
    // UIR update only affects the following command.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir_q        <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            act_q       <= '0;
            no_act_q    <= '0;
        end else begin
            act_q    <= '0;
            no_act_q <= '0;
            if (uir_p) begin
                ir_q <= ir_in;
            end
            if (cmd_accept) begin
                cmd_q.ir    <= ir_q;
                cmd_q.data  <= sr;
                cmd_valid_q <= 1'b1;
                if (sr[ACT_BIT]) begin
                    act_q <= ir_onehot;
                end else begin
                    no_act_q <= ir_onehot;
                end
            end else if (handshake) begin
                cmd_valid_q <= 1'b0;
            end
            if (cmd_accept && cmd_valid_q && !cmd_ready) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign jdo            = cmd_q.data;
    assign cmd_ir         = cmd_q.ir;
    assign cmd_valid      = cmd_valid_q;
    assign take_action    = act_q;
    assign take_no_action = no_act_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_bridge.sv
// Directed bench for jtag_debug_sysclk_bridge: rule-level model compared every cycle, plus literal spot checks.
module tb_jtag_debug_sysclk_bridge;

    localparam int DW   = 38;
    localparam int IW   = 2;
    localparam int NC   = 4;
    localparam int ACT  = 34;
    localparam int LAT  = 3;     // level rise to internal pulse: SYNC_STAGES+1
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vs_uir;
    logic          vs_udr;
    logic [IW-1:0] ir_in;
    logic [DW-1:0] sr;
    logic [DW-1:0] jdo;
    logic [IW-1:0] cmd_ir;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [NC-1:0] take_action;
    logic [NC-1:0] take_no_action;
    logic          overrun;
    logic          overrun_clr;
`ifdef JTAG_BRIDGE_PARITY_EN
    logic          parity_err;
`endif

    jtag_debug_sysclk_bridge dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overrun        (overrun),
        .overrun_clr    (overrun_clr)
`ifdef JTAG_BRIDGE_PARITY_EN
        ,
        .parity_err     (parity_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit            lvl_u [MAXC];
    bit            lvl_d [MAXC];
    bit            rst_a [MAXC];
    int            cyc  = 0;
    bit            live = 0;
    logic [DW-1:0] m_jdo;
    logic [IW-1:0] m_cmd_ir;
    logic [IW-1:0] m_ir;
    bit            m_valid;
    bit            m_ov;
    bit            m_perr;
    logic [NC-1:0] m_act;
    logic [NC-1:0] m_noact;

    // An update strobe counts once its level was seen low then high at two
    // consecutive clean (non-reset) edges, LAT edges ago, with no reset since.
    function automatic bit strobe_event(input int n, input bit is_udr);
        bit now_hi;
        bit prev_hi;
        if (n < LAT + 1) return 1'b0;
        for (int k = n - LAT - 1; k <= n; k++) begin
            if (rst_a[k]) return 1'b0;
        end
        now_hi  = is_udr ? lvl_d[n-LAT]   : lvl_u[n-LAT];
        prev_hi = is_udr ? lvl_d[n-LAT-1] : lvl_u[n-LAT-1];
        return now_hi && !prev_hi;
    endfunction

    always @(posedge clk) begin
        bit uev;
        bit dev;
        bit par_ok;
        if (cyc < MAXC) begin
            rst_a[cyc] = !reset_n;
            lvl_u[cyc] = vs_uir;
            lvl_d[cyc] = vs_udr;
            if (!reset_n) begin
                live = 1;
                m_jdo = '0; m_cmd_ir = '0; m_ir = '0;
                m_valid = 0; m_ov = 0; m_perr = 0;
                m_act = '0; m_noact = '0;
            end else begin
                uev = strobe_event(cyc, 1'b0);
                dev = strobe_event(cyc, 1'b1);
                par_ok = 1'b1;
`ifdef JTAG_BRIDGE_PARITY_EN
                par_ok = ((^sr) == 1'b0);
                if (dev && !par_ok) m_perr = 1;
`endif
                m_act   = '0;
                m_noact = '0;
                if (dev && par_ok) begin
                    if (m_valid && !cmd_ready) m_ov = 1;
                    else if (overrun_clr)      m_ov = 0;
                    m_jdo    = sr;
                    m_cmd_ir = m_ir;
                    m_valid  = 1;
                    if (sr[ACT]) m_act[m_ir]   = 1'b1;
                    else         m_noact[m_ir] = 1'b1;
                end else begin
                    if (overrun_clr)           m_ov = 0;
                    if (m_valid && cmd_ready)  m_valid = 0;
                end
                if (uev) m_ir = ir_in;
            end
            cyc++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (live) begin
            check("model.jdo",            64'(jdo),            64'(m_jdo));
            check("model.cmd_ir",         64'(cmd_ir),         64'(m_cmd_ir));
            check("model.cmd_valid",      64'(cmd_valid),      64'(m_valid));
            check("model.take_action",    64'(take_action),    64'(m_act));
            check("model.take_no_action", 64'(take_no_action), 64'(m_noact));
            check("model.overrun",        64'(overrun),        64'(m_ov));
`ifdef JTAG_BRIDGE_PARITY_EN
            check("model.parity_err",     64'(parity_err),     64'(m_perr));
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic uir_load(input logic [IW-1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        repeat (6) @(negedge clk);
        vs_uir = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // Raises vs_udr with data; returns at the first negedge where the command is visible.
    task automatic udr_start(input logic [DW-1:0] data, input bit clr, input bit rdy);
        sr     = data;
        vs_udr = 1'b1;
        repeat (LAT) @(negedge clk);
        check("lit.no_early_strobe", 64'(take_action | take_no_action), 64'(0));
        overrun_clr = clr;
        cmd_ready   = rdy;
        @(negedge clk);
        overrun_clr = 1'b0;
        cmd_ready   = 1'b0;
    endtask

    task automatic udr_end();
        @(negedge clk);
        check("lit.strobe_one_cycle", 64'(take_action | take_no_action), 64'(0));
        @(negedge clk);
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic consume();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        check("lit.valid_cleared", 64'(cmd_valid), 64'(0));
    endtask

    localparam logic [DW-1:0] VA = 38'h04_0000_1234;
    localparam logic [DW-1:0] VB = 38'h00_0000_1235;
    localparam logic [DW-1:0] VC1 = 38'h04_0000_0001;
    localparam logic [DW-1:0] VC2 = 38'h00_0000_00FF;
    localparam logic [DW-1:0] VD = 38'h3F_FFFF_FFFF;
    localparam logic [DW-1:0] VE = 38'h00_0000_0011;
    localparam logic [DW-1:0] VF = 38'h04_0000_0002;

    initial begin
        logic [NC-1:0] seen;
        reset_n = 1'b0; vs_uir = 1'b0; vs_udr = 1'b1; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; overrun_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("lit.rst_jdo",     64'(jdo),                             64'(0));
        check("lit.rst_valid",   64'(cmd_valid),                       64'(0));
        check("lit.rst_strobes", 64'(take_action | take_no_action),    64'(0));
        check("lit.rst_overrun", 64'(overrun),                         64'(0));
        check("lit.rst_cmd_ir",  64'(cmd_ir),                          64'(0));
        reset_n = 1'b1;
        seen = '0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | take_action | take_no_action;
        end
        check("lit.no_strobe_held_high", 64'(seen), 64'(0));
        vs_udr = 1'b0;
        repeat (6) @(negedge clk);

        // action on IR 2, four cycles after the rise
        uir_load(2'd2);
        udr_start(VA, 1'b0, 1'b0);
        check("lit.A_action",   64'(take_action),    64'(4'b0100));
        check("lit.A_noaction", 64'(take_no_action), 64'(0));
        check("lit.A_jdo",      64'(jdo),            64'(VA));
        check("lit.A_cmd_ir",   64'(cmd_ir),         64'(2));
        check("lit.A_valid",    64'(cmd_valid),      64'(1));
        udr_end();
        consume();

        // no-action on IR 0, held unconsumed
        uir_load(2'd0);
        udr_start(VB, 1'b0, 1'b0);
        check("lit.B_noaction", 64'(take_no_action), 64'(4'b0001));
        udr_end();
        for (int i = 0; i < 10; i++) begin
            check("lit.B_valid_held", 64'(cmd_valid), 64'(1));
            @(negedge clk);
        end
        consume();

        // overrun set, clear, and set-wins-over-clear
        udr_start(VC1, 1'b0, 1'b0);
        udr_end();
        check("lit.C1_no_overrun", 64'(overrun), 64'(0));
        udr_start(VC2, 1'b0, 1'b0);
        check("lit.C2_overrun", 64'(overrun), 64'(1));
        check("lit.C2_jdo",     64'(jdo),     64'(VC2));
        udr_end();
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("lit.overrun_cleared", 64'(overrun), 64'(0));
        udr_start(VD, 1'b1, 1'b0);
        check("lit.D_set_wins", 64'(overrun),     64'(1));
        check("lit.D_action",   64'(take_action), 64'(4'b0001));
        udr_end();
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        // handshake coinciding with a new command: no overrun
        udr_start(VB, 1'b0, 1'b1);
        check("lit.hs_no_overrun", 64'(overrun),   64'(0));
        check("lit.hs_valid",      64'(cmd_valid), 64'(1));
        check("lit.hs_jdo",        64'(jdo),       64'(VB));
        udr_end();
        consume();

        // simultaneous UIR and UDR: old IR used, new IR on next command
        uir_load(2'd1);
        ir_in  = 2'd3;
        vs_uir = 1'b1;
        udr_start(VE, 1'b0, 1'b0);
        check("lit.E_noaction", 64'(take_no_action), 64'(4'b0010));
        check("lit.E_cmd_ir",   64'(cmd_ir),         64'(1));
        udr_end();
        vs_uir = 1'b0;
        udr_start(VF, 1'b1, 1'b0);
        check("lit.F_action", 64'(take_action), 64'(4'b1000));
        check("lit.F_cmd_ir", 64'(cmd_ir),      64'(3));
        udr_end();

`ifdef JTAG_BRIDGE_PARITY_EN
        udr_start(38'h00_0000_0001, 1'b0, 1'b0);
        check("lit.G_no_strobe",  64'(take_action | take_no_action), 64'(0));
        check("lit.G_parity_err", 64'(parity_err), 64'(1));
        check("lit.G_jdo_kept",   64'(jdo),        64'(VF));
        check("lit.G_valid_kept", 64'(cmd_valid),  64'(1));
        udr_end();
        udr_start(38'h20_0000_0001, 1'b0, 1'b0);
        check("lit.H_noaction",   64'(take_no_action), 64'(4'b1000));
        check("lit.H_parity_err", 64'(parity_err),     64'(1));
        udr_end();
`endif
        consume();
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
